fetch_ctrl: RTL and testbench

Fetch-sequencing controller for the Front_End. Owns the architectural fetch PC, issues one 8-byte-aligned request at a time over the icache address/data handshake, and presents each returned 64-bit word as a two-slot fetch pack. Arbitrates next-PC sources by priority:

1. commit redirect
2. branch mispredict
3. BPU taken prediction
4. sequential

Any redirect squashes the in-flight request or pack.

---
 rtl/fetch_ctrl_pkg.sv | 26 ++
 rtl/fetch_next_pc_sel.sv | 30 +++
 rtl/fetch_ctrl.sv | 152 +++++++++++++++
 tb/tb_fetch_ctrl.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared types and constants for the fetch sequencing controller.
package fetch_ctrl_pkg;

    localparam int unsigned FETCH_BYTES = 8;
    localparam int unsigned XLEN        = 64;

    localparam logic [XLEN-1:0] ALIGN_MASK = ~64'h7;
    localparam logic [XLEN-1:0] INST_MASK  = ~64'h3;

    localparam logic [1:0] SLOT_BOTH  = 2'b11;
    localparam logic [1:0] SLOT_UPPER = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WAIT,
        HOLD,
        DRAIN
    } state_e;

    // A PC in the upper half of the word leaves slot 0 behind the fetch point.
    function automatic logic [1:0] slot_valid_of(input logic upper_half);
        return upper_half ? SLOT_UPPER : SLOT_BOTH;
    endfunction

endpackage

// File: rtl/fetch_next_pc_sel.sv
// Priority mux for the next fetch PC: commit redirect, mispredict, BPU taken, sequential.
module fetch_next_pc_sel
    import fetch_ctrl_pkg::*;
#(
    parameter int unsigned STRIDE = 8
) (
    input  logic [XLEN-1:0] pc,
    input  logic            pc_redirect_valid,
    input  logic [XLEN-1:0] pc_redirect_target,
    input  logic            mispred_valid,
    input  logic [XLEN-1:0] mispred_target,
    input  logic            bpu_taken_valid,
    input  logic [XLEN-1:0] bpu_target,
    output logic [XLEN-1:0] next_pc_c,
    output logic            redirect_c
);

    always_comb begin
        next_pc_c  = (pc & ALIGN_MASK) + XLEN'(STRIDE);
        redirect_c = pc_redirect_valid | mispred_valid;
        if (pc_redirect_valid) begin
            next_pc_c = pc_redirect_target & INST_MASK;
        end else if (mispred_valid) begin
            next_pc_c = mispred_target & INST_MASK;
        end else if (bpu_taken_valid) begin
            next_pc_c = bpu_target;
        end
    end

endmodule

// File: rtl/fetch_ctrl.sv
// Fetch PC owner: one icache request at a time, returned word presented as a two-slot pack.
// Optional FETCH_CTRL_PERF_EN adds accepted-pack and dropped-response/pack counters.
module fetch_ctrl #(
    parameter logic [63:0] RESET_PC    = 64'h0,
    parameter int unsigned FETCH_BYTES = 8
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        io_i_pc_redirect_valid,
    input  logic [63:0] io_i_pc_redirect_target,
    input  logic        io_i_mispred_valid,
    input  logic [63:0] io_i_mispred_target,
    input  logic        io_i_bpu_taken_valid,
    input  logic [63:0] io_i_bpu_target,
    output logic [63:0] io_icache_io_o_addr,
    output logic        io_icache_io_o_addr_valid,
    input  logic        io_icache_io_i_addr_ready,
    input  logic [63:0] io_icache_io_i_data,
    input  logic        io_icache_io_i_data_valid,
    output logic        io_o_fetch_pack_valid,
    input  logic        io_o_fetch_pack_ready,
    output logic [63:0] io_o_fetch_pack_pc,
    output logic [63:0] io_o_fetch_pack_insts,
    output logic [1:0]  io_o_fetch_pack_slot_valid,
    output logic        io_o_flush
`ifdef FETCH_CTRL_PERF_EN
    ,
    output logic [31:0] io_o_perf_fetch_cnt,
    output logic [31:0] io_o_perf_drop_cnt
`endif
);

    import fetch_ctrl_pkg::*;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pc_q, pc_d;
    logic [XLEN-1:0]   next_pc_q, next_pc_d;
    logic [XLEN-1:0]   sel_next_pc;
    logic              redirect;
    logic              capture;
    logic              handshake;

    assign handshake           = io_icache_io_o_addr_valid & io_icache_io_i_addr_ready;
    assign io_icache_io_o_addr = pc_q & ALIGN_MASK;

    fetch_next_pc_sel #(
        .STRIDE(FETCH_BYTES)
    ) u_next_pc_sel (
        .pc                 (pc_q),
        .pc_redirect_valid  (io_i_pc_redirect_valid),
        .pc_redirect_target (io_i_pc_redirect_target),
        .mispred_valid      (io_i_mispred_valid),
        .mispred_target     (io_i_mispred_target),
        .bpu_taken_valid    (io_i_bpu_taken_valid),
        .bpu_target         (io_i_bpu_target),
        .next_pc_c          (sel_next_pc),
        .redirect_c         (redirect)
    );

    // Next-state logic; a redirect always retargets the PC and squashes in-flight work.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        next_pc_d = next_pc_q;
        capture   = 1'b0;
        case (state_q)
            IDLE: state_d = REQ;
            REQ: begin
                if (handshake) begin
                    state_d = redirect ? DRAIN : WAIT;
                end
            end
            WAIT: begin
                if (io_icache_io_i_data_valid) begin
                    if (redirect) begin
                        state_d = REQ;
                    end else begin
                        state_d   = HOLD;
                        capture   = 1'b1;
                        next_pc_d = sel_next_pc;
                    end
                end else if (redirect) begin
                    state_d = DRAIN;
                end
            end
            HOLD: begin
                if (redirect) begin
                    state_d = REQ;
                end else if (io_o_fetch_pack_ready) begin
                    state_d = REQ;
                    pc_d    = next_pc_q;
                end
            end
            DRAIN: begin
                if (io_icache_io_i_data_valid) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase
        if (redirect) begin
            pc_d = sel_next_pc;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q                    <= IDLE;
            pc_q                       <= RESET_PC & INST_MASK;
            next_pc_q                  <= '0;
            io_icache_io_o_addr_valid  <= 1'b0;
            io_o_fetch_pack_valid      <= 1'b0;
            io_o_fetch_pack_pc         <= '0;
            io_o_fetch_pack_insts      <= '0;
            io_o_fetch_pack_slot_valid <= '0;
            io_o_flush                 <= 1'b0;
        end else begin
            state_q                   <= state_d;
            pc_q                      <= pc_d;
            next_pc_q                 <= next_pc_d;
            io_icache_io_o_addr_valid <= (state_d == REQ);
            io_o_fetch_pack_valid     <= (state_d == HOLD);
            io_o_flush                <= redirect;
            if (capture) begin
                io_o_fetch_pack_pc         <= pc_q & ALIGN_MASK;
                io_o_fetch_pack_insts      <= io_icache_io_i_data;
                io_o_fetch_pack_slot_valid <= slot_valid_of(pc_q[2]);
            end
        end
    end

`ifdef FETCH_CTRL_PERF_EN
    logic pack_accept;
    logic pack_drop;

    assign pack_accept = (state_q == HOLD) & ~redirect & io_o_fetch_pack_ready;
    assign pack_drop   = (redirect & (((state_q == WAIT) & io_icache_io_i_data_valid) |
                                      (state_q == HOLD))) |
                         ((state_q == DRAIN) & io_icache_io_i_data_valid);

    always_ff @(posedge clock) begin
        if (reset) begin
            io_o_perf_fetch_cnt <= '0;
            io_o_perf_drop_cnt  <= '0;
        end else begin
            if (pack_accept) io_o_perf_fetch_cnt <= io_o_perf_fetch_cnt + 32'd1;
            if (pack_drop)   io_o_perf_drop_cnt  <= io_o_perf_drop_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed scenarios then random traffic against a transaction-level model.
module tb_fetch_ctrl;

    localparam logic [63:0] RST_PC = 64'h1000;

    logic        clock = 1'b0;
    logic        reset;
    logic        io_i_pc_redirect_valid;
    logic [63:0] io_i_pc_redirect_target;
    logic        io_i_mispred_valid;
    logic [63:0] io_i_mispred_target;
    logic        io_i_bpu_taken_valid;
    logic [63:0] io_i_bpu_target;
    logic [63:0] io_icache_io_o_addr;
    logic        io_icache_io_o_addr_valid;
    logic        io_icache_io_i_addr_ready;
    logic [63:0] io_icache_io_i_data;
    logic        io_icache_io_i_data_valid;
    logic        io_o_fetch_pack_valid;
    logic        io_o_fetch_pack_ready;
    logic [63:0] io_o_fetch_pack_pc;
    logic [63:0] io_o_fetch_pack_insts;
    logic [1:0]  io_o_fetch_pack_slot_valid;
    logic        io_o_flush;

    fetch_ctrl #(.RESET_PC(RST_PC), .FETCH_BYTES(8)) dut (
        .clock                      (clock),
        .reset                      (reset),
        .io_i_pc_redirect_valid     (io_i_pc_redirect_valid),
        .io_i_pc_redirect_target    (io_i_pc_redirect_target),
        .io_i_mispred_valid         (io_i_mispred_valid),
        .io_i_mispred_target        (io_i_mispred_target),
        .io_i_bpu_taken_valid       (io_i_bpu_taken_valid),
        .io_i_bpu_target            (io_i_bpu_target),
        .io_icache_io_o_addr        (io_icache_io_o_addr),
        .io_icache_io_o_addr_valid  (io_icache_io_o_addr_valid),
        .io_icache_io_i_addr_ready  (io_icache_io_i_addr_ready),
        .io_icache_io_i_data        (io_icache_io_i_data),
        .io_icache_io_i_data_valid  (io_icache_io_i_data_valid),
        .io_o_fetch_pack_valid      (io_o_fetch_pack_valid),
        .io_o_fetch_pack_ready      (io_o_fetch_pack_ready),
        .io_o_fetch_pack_pc         (io_o_fetch_pack_pc),
        .io_o_fetch_pack_insts      (io_o_fetch_pack_insts),
        .io_o_fetch_pack_slot_valid (io_o_fetch_pack_slot_valid),
        .io_o_flush                 (io_o_flush)
    );

    always #5 clock = ~clock;

    int total = 0;
    int bad   = 0;
    int accepted = 0;

    // stimulus knobs
    bit          k_rand = 0, k_addr_ready = 1, k_pack_ready = 1, k_fixed = 1;
    int unsigned k_lat = 0;
    logic [63:0] k_data = 64'h00510213_00510113;
    bit          k_redir = 0, k_mis = 0, k_bpu = 0;
    logic [63:0] k_rt = '0, k_mt = '0, k_bt = '0;

    // reference model: architectural PC, icache occupancy, presented pack
    logic [63:0] exp_pc, exp_next, exp_pack_pc, exp_insts;
    logic [1:0]  exp_slot;
    bit          pending, ic_busy, stale, exp_flush;
    int unsigned ic_timer;

    // last sampled outputs
    logic [63:0] o_addr, o_ppc, o_insts;
    logic        o_av, o_pv, o_flush;
    logic [1:0]  o_slot;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic sample();
        o_addr  = io_icache_io_o_addr;
        o_av    = io_icache_io_o_addr_valid;
        o_pv    = io_o_fetch_pack_valid;
        o_ppc   = io_o_fetch_pack_pc;
        o_insts = io_o_fetch_pack_insts;
        o_slot  = io_o_fetch_pack_slot_valid;
        o_flush = io_o_flush;
    endtask

    task automatic tick();
        logic dv, hs, acc, rd, rv, mv, bv, ar, pr;
        logic [63:0] rt, mt, bt, d;
        int unsigned lat;
        @(negedge clock);
        dv = ic_busy && (ic_timer == 0);
        if (ic_busy && ic_timer != 0) ic_timer--;
        d = k_fixed ? k_data : {$urandom(), $urandom()};
        if (k_rand) begin
            ar  = ($urandom_range(0, 9) < 6);
            pr  = ($urandom_range(0, 9) < 6);
            rv  = ($urandom_range(0, 19) == 0);
            mv  = ($urandom_range(0, 19) == 0);
            bv  = ($urandom_range(0, 3) == 0);
            rt  = {$urandom(), $urandom()};
            mt  = {$urandom(), $urandom()};
            bt  = {$urandom(), $urandom()};
            lat = $urandom_range(0, 3);
        end else begin
            ar = k_addr_ready; pr = k_pack_ready;
            rv = k_redir; mv = k_mis; bv = k_bpu;
            rt = k_rt; mt = k_mt; bt = k_bt; lat = k_lat;
        end
        k_redir = 0; k_mis = 0; k_bpu = 0;
        io_icache_io_i_addr_ready = ar;
        io_o_fetch_pack_ready     = pr;
        io_icache_io_i_data_valid = dv;
        io_icache_io_i_data       = d;
        io_i_pc_redirect_valid    = rv;
        io_i_pc_redirect_target   = rt;
        io_i_mispred_valid        = mv;
        io_i_mispred_target       = mt;
        io_i_bpu_taken_valid      = bv;
        io_i_bpu_target           = bt;
        sample();
        chk("flush", 64'(o_flush), 64'(exp_flush));
        chk("addr_valid", 64'(o_av), 64'(!ic_busy && !pending));
        if (o_av) chk("addr", o_addr, exp_pc & ~64'h7);
        chk("pack_valid", 64'(o_pv), 64'(pending));
        if (pending) begin
            chk("pack_pc", o_ppc, exp_pack_pc);
            chk("pack_insts", o_insts, exp_insts);
            chk("pack_slot", 64'(o_slot), 64'(exp_slot));
        end
        hs  = o_av && ar;
        acc = o_pv && pr;
        rd  = rv || mv;
        @(posedge clock);
        if (rd) begin
            exp_pc = (rv ? rt : mt) & ~64'h3;
            if (hs) begin
                ic_busy = 1; ic_timer = lat; stale = 1;
            end else if (ic_busy && dv) begin
                ic_busy = 0; stale = 0;
            end else if (ic_busy) begin
                stale = 1;
            end
            pending = 0;
        end else begin
            if (hs) begin
                ic_busy = 1; ic_timer = lat; stale = 0;
            end
            if (dv) begin
                ic_busy = 0;
                if (!stale) begin
                    pending     = 1;
                    exp_insts   = d;
                    exp_pack_pc = exp_pc & ~64'h7;
                    exp_slot    = exp_pc[2] ? 2'b10 : 2'b11;
                    exp_next    = bv ? bt : (exp_pc & ~64'h7) + 64'd8;
                end
                stale = 0;
            end
            if (acc) begin
                pending = 0;
                exp_pc  = exp_next;
                accepted++;
            end
        end
        exp_flush = rd;
    endtask

    task automatic do_reset(input bit late_dv);
        @(negedge clock);
        reset = 1;
        io_i_pc_redirect_valid = 0; io_i_mispred_valid = 0; io_i_bpu_taken_valid = 0;
        io_icache_io_i_data_valid = 0; io_icache_io_i_addr_ready = 0; io_o_fetch_pack_ready = 0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        sample();
        chk("rst_addr_valid", 64'(o_av), 64'd0);
        chk("rst_pack_valid", 64'(o_pv), 64'd0);
        chk("rst_slot", 64'(o_slot), 64'd0);
        chk("rst_flush", 64'(o_flush), 64'd0);
        chk("rst_insts", o_insts, 64'd0);
        chk("rst_pack_pc", o_ppc, 64'd0);
        chk("rst_addr", o_addr, RST_PC);
        reset = 0;
        io_icache_io_i_data_valid = late_dv;
        io_icache_io_i_data = 64'hDEAD_BEEF_CAFE_F00D;
        exp_pc = RST_PC; pending = 0; ic_busy = 0; stale = 0; exp_flush = 0;
        @(posedge clock);
    endtask

    initial begin
        logic [63:0] held_pc;
        reset = 1;
        io_i_pc_redirect_valid = 0; io_i_pc_redirect_target = '0;
        io_i_mispred_valid = 0; io_i_mispred_target = '0;
        io_i_bpu_taken_valid = 0; io_i_bpu_target = '0;
        io_icache_io_i_addr_ready = 0; io_icache_io_i_data = '0;
        io_icache_io_i_data_valid = 0; io_o_fetch_pack_ready = 0;

        // basic fetch from RESET_PC, 1-cycle icache
        do_reset(0);
        tick(); chk("first_req", o_addr, 64'h1000);
        tick();
        tick();
        chk("tp1_pack_pc", o_ppc, 64'h1000);
        chk("tp1_insts", o_insts, 64'h00510213_00510113);
        chk("tp1_slot", 64'(o_slot), 64'd3);
        k_lat = 2;
        tick(); chk("tp1_next_req", o_addr, 64'h1008);

        // redirect in WAIT without data -> drain one response
        k_redir = 1; k_rt = 64'h8;
        tick();
        tick(); chk("tp2_flush", 64'(o_flush), 64'd1);
        tick();
        k_lat = 0;
        tick(); chk("tp2_req", o_addr, 64'h8);
        tick();
        k_redir = 1; k_rt = 64'h61230; k_mis = 1; k_mt = 64'h890a;
        tick(); chk("tp2_slot", 64'(o_slot), 64'd3);

        // simultaneous redirect and mispredict in HOLD with ready
        tick(); chk("tp3_req", o_addr, 64'h61230);
        chk("tp3_pack_dropped", 64'(o_pv), 64'd0);

        // BPU taken in the data cycle
        k_bpu = 1; k_bt = 64'h5678;
        tick();
        tick();
        k_addr_ready = 0; k_redir = 1; k_rt = 64'h4324;
        tick(); chk("tp4_bpu_req", o_addr, 64'h5678);

        // redirect to an upper-half PC
        k_addr_ready = 1;
        tick(); chk("tp5_req", o_addr, 64'h4320);
        tick();
        k_pack_ready = 0;
        tick(); chk("tp5_slot", 64'(o_slot), 64'd2);
        held_pc = o_ppc;

        // decode backpressure holds the pack
        repeat (4) begin
            tick();
            chk("bp_pack_stable", o_ppc, held_pc);
            chk("bp_no_req", 64'(o_av), 64'd0);
        end
        k_pack_ready = 1;
        tick();
        k_addr_ready = 0; k_redir = 1; k_rt = 64'hFFFF_FFFF_FFFF_FFF8;
        tick(); chk("bp_next_req", o_addr, 64'h4328);

        // sequential wrap
        k_addr_ready = 1;
        tick(); chk("wrap_req", o_addr, 64'hFFFF_FFFF_FFFF_FFF8);
        tick();
        tick();
        k_lat = 3;
        tick(); chk("wrap_next", o_addr, 64'h0);

        // reset while waiting, then a late response in IDLE
        tick();
        do_reset(1);
        tick();
        chk("late_dv_req", o_addr, RST_PC);
        chk("late_dv_no_pack", 64'(o_pv), 64'd0);

        // random traffic
        k_rand = 1; k_fixed = 0;
        accepted = 0;
        repeat (3000) tick();
        chk("progress", 64'(accepted >= 50), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
